multicore_launch_ctrl: RTL

//  Parametrised launch/completion controller for an N-core matrix machine.

---
 rtl/multicore_launch_ctrl.sv | 211 +++++++++++++++++++++
 1 files changed

// File: rtl/multicore_launch_ctrl.sv
// -----------------------------------------------------------------------------
// multicore_launch_ctrl
//   Launch/completion controller for an N-core matrix machine.
//   A start request opens a core reset window of RESET_HOLD cycles. The enabled
//   cores are then released, and each core's end_process is recorded as a sticky
//   done bit. DONE is reported once every enabled core has finished.
//   All outputs are registered. Reset is asynchronous and active-low.
//
//   Optional feature macro: MCL_WATCHDOG_EN
//     defined   : the RUN phase is bounded by TIMEOUT run cycles. Expiry ends the
//                 job in DONE with timeout=1, and done_mask keeps the partial result.
//     undefined : there is no watchdog, timeout is tied low, and RUN waits
//                 indefinitely.
// -----------------------------------------------------------------------------
module multicore_launch_ctrl #(
    parameter int NUM_CORES  = 4,
    parameter int RESET_HOLD = 10,
    parameter int CNT_W      = 16,
    parameter int TIMEOUT    = 32'h0000_FFF0
) (
    input  logic                 clock,
    input  logic                 rst_n,
    input  logic                 start_process,
    input  logic [NUM_CORES-1:0] core_enable,
    input  logic [NUM_CORES-1:0] end_process,
    output logic [NUM_CORES-1:0] core_rst,
    output logic                 begin_process,
    output logic [1:0]           status,
    output logic [NUM_CORES-1:0] done_mask,
    output logic [CNT_W-1:0]     run_cycles,
    output logic                 timeout
);

    // The state encoding doubles as the status output code.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RESET = 2'b01,
        ST_RUN   = 2'b10,
        ST_DONE  = 2'b11
    } state_t;

    // The hold counter only has to reach RESET_HOLD-1.
    localparam int                HOLD_W    = (RESET_HOLD > 1) ? $clog2(RESET_HOLD) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RESET_HOLD - 1);

    // Elaboration-time guard against unsupported parameter values.
    if (NUM_CORES < 1 || NUM_CORES > 16 || RESET_HOLD < 1 || CNT_W < 2 ||
        TIMEOUT < 2 || (CNT_W < 31 && TIMEOUT > ((1 << CNT_W) - 1))) begin : g_param_check
        $error("multicore_launch_ctrl: parameter out of supported range");
    end

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [NUM_CORES-1:0]   r_en_lat;
    logic [NUM_CORES-1:0]   w_en_lat_nxt;
    logic [HOLD_W-1:0]      r_hold_cnt;
    logic [HOLD_W-1:0]      w_hold_nxt;
    logic [NUM_CORES-1:0]   r_core_rst;
    logic [NUM_CORES-1:0]   w_core_rst_nxt;
    logic                   r_begin;
    logic                   w_begin_nxt;
    logic [NUM_CORES-1:0]   r_done_mask;
    logic [NUM_CORES-1:0]   w_done_mask_nxt;
    logic [CNT_W-1:0]       r_run_cycles;
    logic [CNT_W-1:0]       w_run_cycles_nxt;

    logic [NUM_CORES-1:0]   w_new_mask;
    logic                   w_all_done;
    logic [CNT_W-1:0]       w_run_inc;

`ifdef MCL_WATCHDOG_EN
    // The last run-cycle value that is still inside the watchdog window.
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);

    logic                   r_timeout;
    logic                   w_timeout_nxt;
`endif

    // Finished cores including this cycle's flags. Disabled cores are masked out.
    assign w_new_mask = r_done_mask | (end_process & r_en_lat);
    assign w_all_done = ((w_new_mask & r_en_lat) == r_en_lat);
    assign w_run_inc  = (r_run_cycles == {CNT_W{1'b1}}) ? r_run_cycles
                                                       : r_run_cycles + CNT_W'(1);

    // State register.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic, plus the next values of the job registers and outputs.
    always_comb begin
        w_state_nxt      = r_state;
        w_en_lat_nxt     = r_en_lat;
        w_hold_nxt       = r_hold_cnt;
        w_done_mask_nxt  = r_done_mask;
        w_run_cycles_nxt = r_run_cycles;
`ifdef MCL_WATCHDOG_EN
        w_timeout_nxt    = r_timeout;
`endif

        case (r_state)
            ST_IDLE: begin
                if (start_process) begin
                    // A new job latches the core set and clears the last job's results.
                    w_state_nxt      = ST_RESET;
                    w_hold_nxt       = '0;
                    w_en_lat_nxt     = core_enable;
                    w_done_mask_nxt  = '0;
                    w_run_cycles_nxt = '0;
`ifdef MCL_WATCHDOG_EN
                    w_timeout_nxt    = 1'b0;
`endif
                end
            end

            ST_RESET: begin
                if (!start_process) begin
                    w_state_nxt = ST_IDLE;
                end else if (r_hold_cnt == HOLD_LAST) begin
                    w_state_nxt = ST_RUN;
                end else begin
                    w_hold_nxt = r_hold_cnt + HOLD_W'(1);
                end
            end

            ST_RUN: begin
                if (!start_process) begin
                    // On abort, the partial results stay visible and are not updated.
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_done_mask_nxt  = w_new_mask;
                    w_run_cycles_nxt = w_run_inc;
                    if (w_all_done) begin
                        w_state_nxt = ST_DONE;
                    end
`ifdef MCL_WATCHDOG_EN
                    else if (r_run_cycles == TO_LAST) begin
                        w_state_nxt   = ST_DONE;
                        w_timeout_nxt = 1'b1;
                    end
`endif
                end
            end

            ST_DONE: begin
                if (!start_process) begin
                    w_state_nxt = ST_IDLE;
                end
            end

            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        // Outputs are derived from the next state so that they are registered
        // together with the state register.
        w_begin_nxt = (w_state_nxt == ST_RUN);
        if (w_state_nxt == ST_RUN || w_state_nxt == ST_DONE) begin
            // Enabled cores stay out of reset through DONE so their results remain readable.
            w_core_rst_nxt = ~w_en_lat_nxt;
        end else begin
            w_core_rst_nxt = {NUM_CORES{1'b1}};
        end
    end

    // Job registers and registered outputs.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            r_en_lat     <= '0;
            r_hold_cnt   <= '0;
            r_core_rst   <= {NUM_CORES{1'b1}};
            r_begin      <= 1'b0;
            r_done_mask  <= '0;
            r_run_cycles <= '0;
        end else begin
            r_en_lat     <= w_en_lat_nxt;
            r_hold_cnt   <= w_hold_nxt;
            r_core_rst   <= w_core_rst_nxt;
            r_begin      <= w_begin_nxt;
            r_done_mask  <= w_done_mask_nxt;
            r_run_cycles <= w_run_cycles_nxt;
        end
    end

`ifdef MCL_WATCHDOG_EN
    // Watchdog expiry flag. It is cleared only when the next job is launched.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            r_timeout <= 1'b0;
        end else begin
            r_timeout <= w_timeout_nxt;
        end
    end

    assign timeout = r_timeout;
`else
    assign timeout = 1'b0;
`endif

    assign status        = r_state;
    assign core_rst      = r_core_rst;
    assign begin_process = r_begin;
    assign done_mask     = r_done_mask;
    assign run_cycles    = r_run_cycles;

endmodule
